// File: rtl/pipe_stall_ctrl.sv
// Hazard scheduler beside ID: load-use and MDU stalls, IF flush, MDU launch and busy tracking.
// Optional STALL_PERF_EN adds free-running stall and flush event counters.
module pipe_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_is_md,
  input  logic       id_is_div,
  input  logic       id_reads_hilo,
  input  logic       id_br_taken,
  input  logic [4:0] ern,
  input  logic       ewreg,
  input  logic       em2reg,
  output logic       wpcir,
  output logic       dbubble,
  output logic       if_flush,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done,
`ifdef STALL_PERF_EN
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_md_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [1:0] stall_why
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  // Counter holds remaining busy cycles minus one so md_done lines up with zero.
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_hit, rt_hit;
  logic lu_hz, md_hz, stall;
  logic busy_raw, start_raw, done_raw;

  always_comb begin
    rs_hit    = id_use_rs & (id_rs == ern);
    rt_hit    = id_use_rt & (id_rt == ern);
    lu_hz     = ewreg & em2reg & (ern != 5'd0) & (rs_hit | rt_hit);
    busy_raw  = (state_q == BUSY);
    md_hz     = busy_raw & (id_is_md | id_reads_hilo);
    stall     = lu_hz | md_hz;
    start_raw = (state_q == IDLE) & id_is_md & ~stall;
    done_raw  = busy_raw & (cnt_q == '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_raw) begin
          state_d = BUSY;
          cnt_d   = id_is_div ? DIV_LD : MUL_LD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are pinned to their idle values while reset is held.
  always_comb begin
    wpcir     = 1'b1;
    dbubble   = 1'b0;
    if_flush  = 1'b0;
    md_start  = 1'b0;
    md_busy   = 1'b0;
    md_done   = 1'b0;
    stall_why = 2'b00;
    if (!reset) begin
      wpcir    = ~stall;
      dbubble  = stall;
      if_flush = id_br_taken & ~stall;
      md_start = start_raw;
      md_busy  = busy_raw;
      md_done  = done_raw;
      if (lu_hz)      stall_why = 2'b01;
      else if (md_hz) stall_why = 2'b10;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_lu_q, perf_md_q, perf_flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_lu_q    <= '0;
      perf_md_q    <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_why == 2'b01) perf_lu_q    <= perf_lu_q + 32'd1;
      if (stall_why == 2'b10) perf_md_q    <= perf_md_q + 32'd1;
      if (if_flush)           perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_lu_cnt    = perf_lu_q;
  assign perf_md_cnt    = perf_md_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; outputs packed as
// {wpcir,dbubble,if_flush,md_start,md_busy,md_done,stall_why[1:0]}.
module tb_pipe_stall_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ern;
  logic       id_use_rs, id_use_rt, id_is_md, id_is_div, id_reads_hilo, id_br_taken;
  logic       ewreg, em2reg;
  logic       wpcir, dbubble, if_flush, md_start, md_busy, md_done;
  logic [1:0] stall_why;
`ifdef STALL_PERF_EN
  logic [31:0] perf_lu_cnt, perf_md_cnt, perf_flush_cnt;
  logic [31:0] lu0, md0, fl0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_stall_ctrl dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_md(id_is_md), .id_is_div(id_is_div), .id_reads_hilo(id_reads_hilo),
    .id_br_taken(id_br_taken), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
    .wpcir(wpcir), .dbubble(dbubble), .if_flush(if_flush), .md_start(md_start),
    .md_busy(md_busy), .md_done(md_done),
`ifdef STALL_PERF_EN
    .perf_lu_cnt(perf_lu_cnt), .perf_md_cnt(perf_md_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .stall_why(stall_why)
  );

  localparam logic [7:0] IDL  = 8'b1000_0000; // no stall, MDU idle
  localparam logic [7:0] LU   = 8'b0100_0001; // load-use stall
  localparam logic [7:0] FLS  = 8'b1010_0000; // flush
  localparam logic [7:0] STRT = 8'b1001_0000; // md_start
  localparam logic [7:0] MDS  = 8'b0100_1010; // MDU stall, busy
  localparam logic [7:0] MDSD = 8'b0100_1110; // MDU stall, busy, done
  localparam logic [7:0] BSY  = 8'b1000_1000; // busy, no stall
  localparam logic [7:0] BSYD = 8'b1000_1100; // busy, done, no stall

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = {wpcir, dbubble, if_flush, md_start, md_busy, md_done, stall_why};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; ern = 5'd0;
    id_use_rs = 0; id_use_rt = 0; id_is_md = 0; id_is_div = 0;
    id_reads_hilo = 0; id_br_taken = 0; ewreg = 0; em2reg = 0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    ern = r; ewreg = 1; em2reg = 1; id_rs = 5; id_use_rs = 1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    cyc(); cyc();
    // Hazards present during reset must not leak out
    set_lu(5'd5); id_is_md = 1; id_br_taken = 1;
    #3 chk("reset_forced", IDL);

    cyc(); reset = 0; clr();
    #3 chk("idle_after_reset", IDL);

    // Load-use: exactly one stall cycle
    cyc(); set_lu(5'd5);
    #3 chk("lu_stall", LU);
    cyc(); clr(); id_rs = 5; id_use_rs = 1;
    #3 chk("lu_released", IDL);
    cyc(); set_lu(5'd0);
    #3 chk("lu_r0_nostall", IDL);
    cyc(); clr(); ern = 7; ewreg = 1; em2reg = 1; id_rt = 7; id_use_rt = 0;
    #3 chk("lu_rt_unused", IDL);
    cyc(); id_use_rt = 1;
    #3 chk("lu_rt_used", LU);
    cyc(); clr(); ern = 7; ewreg = 1; em2reg = 0; id_rt = 7; id_use_rt = 1;
    #3 chk("lu_not_load", IDL);

    // Taken branch coincident with load-use
    cyc(); clr(); set_lu(5'd5); id_br_taken = 1;
    #3 chk("br_lu_noflush", LU);
    cyc(); clr(); id_br_taken = 1;
    #3 chk("br_flush", FLS);

    // mult + lu in IDLE: no start, replayed next cycle
    cyc(); clr(); set_lu(5'd5); id_is_md = 1;
    #3 chk("md_lu_nostart", LU);

    // mult then mfhi
    cyc(); clr(); id_is_md = 1;
`ifdef STALL_PERF_EN
    lu0 = perf_lu_cnt; md0 = perf_md_cnt; fl0 = perf_flush_cnt;
`endif
    #3 chk("mul_start", STRT);
    for (int i = 1; i <= 3; i++) begin
      cyc(); clr(); id_reads_hilo = 1;
      #3 chk("mfhi_stall", MDS);
    end
    cyc(); #3 chk("mfhi_stall_done", MDSD);
    cyc(); #3 chk("mfhi_go", IDL);
    cyc(); clr();
`ifdef STALL_PERF_EN
    chk32("perf_md", perf_md_cnt - md0, 32'd4);
    chk32("perf_lu", perf_lu_cnt - lu0, 32'd0);
    chk32("perf_flush", perf_flush_cnt - fl0, 32'd0);
`endif
    #3 chk("post_mul_idle", IDL);

    // Back-to-back div: second starts 33 cycles after first
    cyc(); id_is_md = 1; id_is_div = 1;
    #3 chk("div1_start", STRT);
    for (int i = 1; i <= 31; i++) begin
      cyc(); #3 chk("div2_wait", MDS);
    end
    cyc(); #3 chk("div2_wait_done", MDSD);
    cyc(); #3 chk("div2_start", STRT);
    // Unrelated adds during BUSY flow freely
    for (int i = 1; i <= 31; i++) begin
      cyc(); clr(); id_rs = 3; id_use_rs = 1;
      #3 chk("add_in_busy", BSY);
    end
    cyc(); #3 chk("add_div_done", BSYD);
    cyc(); #3 chk("div_idle", IDL);

    // Reset in the 10th BUSY cycle of a div
    cyc(); clr(); id_is_md = 1; id_is_div = 1;
    #3 chk("div3_start", STRT);
    for (int i = 1; i <= 9; i++) begin
      cyc(); clr();
      #3 chk("div3_busy", BSY);
    end
    cyc(); reset = 1;
    #3 chk("reset_in_busy", IDL);
    cyc(); reset = 0;
    #3 chk("after_busy_reset", IDL);
    cyc(); id_is_md = 1;
    #3 chk("mul_after_reset", STRT);
    for (int i = 1; i <= 3; i++) begin
      cyc(); clr();
      #3 chk("mul2_busy", BSY);
    end
    cyc(); #3 chk("mul2_done", BSYD);
    cyc(); #3 chk("mul2_idle", IDL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline hazard scheduler for the 5-stage CPU, placed beside the ID stage. It decides each cycle whether the IF/ID latches and PC advance, whether ID injects a bubble into EXE, and whether IF is flushed. It also sequences the shared multi-cycle multiply/divide unit (MDU): it issues start pulses, tracks busy time with a counter, and stalls HI/LO consumers until the result is ready.

## Interface
- MUL_LAT, 4: MDU busy cycles for mult/multu, range 1..2^CNT_W-1.
- DIV_LAT, 32: MDU busy cycles for div/divu, range 1..2^CNT_W-1.
- CNT_W, 6: busy-counter width.
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  the ID instruction actually reads rs or rt.
- id_is_md  in  1  the ID instruction is mult/multu/div/divu.
- id_is_div  in  1  qualifies id_is_md: 1 = divide, 0 = multiply.
- id_reads_hilo  in  1  the ID instruction is mfhi or mflo.
- id_br_taken  in  1  the ID instruction is a taken branch or jump (pcsource != 0).
- ern  in  5  destination register of the instruction in EXE.
- ewreg, em2reg  in  1 each  the EXE instruction writes the regfile, and is a load.
- wpcir  out  1  PC and IF/ID write enable; 0 = hold.
- dbubble  out  1  forces dwreg, dm2reg and dwmem to 0 into EXE.
- if_flush  out  1  converts the IF/ID latch content to a nop.
- md_start  out  1  one-cycle MDU launch pulse.
- md_busy  out  1  the MDU holds an unfinished operation.
- md_done  out  1  one-cycle pulse on the last busy cycle.
- stall_why  out  2  00 none, 01 load-use, 10 MDU, 11 reserved (never driven).

## Operation
- lu_hz = ewreg & em2reg & (ern != 0) & ((id_use_rs & id_rs == ern) | (id_use_rt & id_rt == ern)).
- md_hz = md_busy & (id_is_md | id_reads_hilo).
- stall = lu_hz | md_hz. Outputs: wpcir = ~stall, dbubble = stall.
- stall_why: 01 when lu_hz; 10 when md_hz and not lu_hz (lu_hz has priority).
- if_flush = id_br_taken & ~stall. A stalled branch does not flush; it is re-evaluated on the next cycle.
- MDU FSM has two states, IDLE and BUSY.
- IDLE: md_start = id_is_md & ~stall. On md_start, the counter loads (id_is_div ? DIV_LAT : MUL_LAT) - 1 and the FSM goes to BUSY.
- BUSY: md_busy = 1. The counter decrements each cycle. When the counter is 0, md_done = 1 and the FSM goes to IDLE on that edge.
- BUSY never issues md_start. A new mult/div in ID stalls until the first IDLE cycle, then starts in that cycle.
- All combinational outputs are forced to their reset values while reset = 1.

## Timing
- Reset values: wpcir=1, dbubble=0, if_flush=0, md_start=0, md_busy=0, md_done=0, stall_why=00. State is IDLE and the counter is 0.
- Load-use: a one-cycle stall. The next cycle the load is in MEM, the normal MEM forward (fw=11) applies, and ern no longer matches.
- MDU: with md_start in cycle T, md_busy=1 in cycles T+1..T+LAT and md_done=1 in cycle T+LAT.
- A stalled mfhi/mflo proceeds in cycle T+LAT+1.
- Back-to-back: a second mult waiting in ID gets md_start in T+LAT+1.
- Simultaneous lu_hz and id_is_md in IDLE: no md_start. The instruction is replayed next cycle.
- Counter wrap is impossible: it loads at most 2^CNT_W-1 and stops at 0.
- Reset asserted in BUSY: next cycle IDLE, md_busy=0, no md_done pulse. The MDU result is discarded.

## Configuration
- STALL_PERF_EN defined: adds the outputs perf_lu_cnt[31:0], perf_md_cnt[31:0] and perf_flush_cnt[31:0].
  - Each counts cycles with stall_why==01, stall_why==10, and if_flush==1, respectively.
  - All three clear on reset and wrap modulo 2^32.
- STALL_PERF_EN undefined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- Load-use: ern=5, ewreg=1, em2reg=1, id_rs=5, id_use_rs=1 -> exactly one cycle with wpcir=0, dbubble=1, stall_why=01. Same case with ern=0 -> no stall.
- Multiply then mfhi: mult in ID at T (MUL_LAT=4), mfhi behind it -> md_start at T, md_busy T+1..T+4, md_done at T+4, mfhi stalled T+1..T+4 with stall_why=10, wpcir=1 at T+5.
- Back-to-back div (DIV_LAT=32): second div gets md_start exactly 33 cycles after the first. Unrelated add instructions during BUSY do not stall.
- Taken branch coincident with lu_hz -> if_flush=0 that cycle; if_flush=1 the following cycle.
- Reset at the 10th BUSY cycle of a div -> next cycle md_busy=0, wpcir=1, no md_done; a later mult starts normally.
- With STALL_PERF_EN: the mult/mfhi scenario yields perf_md_cnt=4, perf_lu_cnt=0, perf_flush_cnt=0.
